// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_pkg
// Description : Shared types, field-select encodings, range limits and BCD
//               helper functions for the time_keeper_bcd slice.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_pkg;

   typedef logic [3:0] digit_t;
   typedef logic [7:0] field_t;

   typedef enum logic [1:0] {
      SEL_SEC  = 2'd0,
      SEL_MIN  = 2'd1,
      SEL_HOUR = 2'd2,
      SEL_NONE = 2'd3
   } sel_e;

   localparam field_t MAX_SEC    = 8'h59;
   localparam field_t MAX_MIN    = 8'h59;
   localparam field_t MAX_HOUR   = 8'h23;
   localparam field_t MAX_HOUR12 = 8'h12;
   localparam digit_t MAX_DIGIT  = 4'd9;

   // Binary 0..99 to packed two-digit BCD
   function automatic field_t bin_to_bcd(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   // Packed two-digit BCD to binary
   function automatic logic [6:0] bcd_to_bin(input field_t v);
      return (7'(v[7:4]) * 7'd10) + 7'(v[3:0]);
   endfunction

   // True when both digits are decimal and the value does not exceed max
   function automatic logic bcd_legal(input field_t v, input field_t max);
      return (v[7:4] <= MAX_DIGIT) && (v[3:0] <= MAX_DIGIT) && (v <= max);
   endfunction

   // Modulo increment; any illegal value collapses to 00
   function automatic field_t bcd_inc(input field_t v, input field_t max);
      if (!bcd_legal(v, max) || (v == max))
         return 8'h00;
      else if (v[3:0] == MAX_DIGIT)
         return {v[7:4] + 4'd1, 4'd0};
      else
         return {v[7:4], v[3:0] + 4'd1};
   endfunction

   // 24-hour BCD to {pm, 12-hour BCD 01..12}
   function automatic logic [8:0] hour24_to_12(input field_t h24);
      logic [6:0] h;
      logic       pm;
      h  = bcd_to_bin(h24);
      pm = (h >= 7'd12);
      if (pm)
         h = h - 7'd12;
      if (h == 7'd0)
         h = 7'd12;
      return {pm, bin_to_bcd(h)};
   endfunction

   // 12-hour BCD 01..12 plus pm flag back to 24-hour BCD
   function automatic field_t hour12_to_24(input field_t h12, input logic pm);
      logic [6:0] h;
      h = bcd_to_bin(h12);
      if (h == 7'd12)
         h = 7'd0;
      if (pm)
         h = h + 7'd12;
      return bin_to_bcd(h);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_mod_counter
// Description : Two-digit packed BCD counter, modulo (MAX_VAL+1), with
//               parallel load and a combinational wrap flag that is high
//               when an increment is about to roll MAX_VAL over to 00.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_mod_counter
   import clock_pkg::*;
#(
   parameter field_t MAX_VAL  = MAX_SEC,
   parameter field_t INIT_VAL = 8'h00
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   i_inc,
   input  logic   i_load,
   input  field_t i_load_val,
   output field_t o_value,
   output logic   o_wrap
);

   field_t value_q;
   field_t value_d;

   // Next value: load beats increment, otherwise hold
   always_comb begin
      value_d = value_q;
      if (i_load)
         value_d = i_load_val;
      else if (i_inc)
         value_d = bcd_inc(value_q, MAX_VAL);
   end

   // Field register with synchronous reset to the elaborated init value
   always_ff @(posedge clk) begin
      if (rst)
         value_q <= INIT_VAL;
      else
         value_q <= value_d;
   end

   assign o_value = value_q;
   // Only a genuine MAX_VAL -> 00 roll counts; an illegal value forced to 00 does not carry
   assign o_wrap  = i_inc && !i_load && (value_q == MAX_VAL);

endmodule
`default_nettype wire

// File: rtl/time_keeper_bcd.sv
`default_nettype none
// ============================================================================
// Module      : time_keeper_bcd
// Description : BCD time-of-day counter driven by a 1 Hz enable. Supports
//               per-field adjust, validated parallel load and registered
//               minute/hour/day carry pulses.
//               Optional macro HOUR12_MODE_EN: 12-hour display with pm flag
//               and a load_pm input; internal state stays 24-hour.
// Revision    : 1.0 - initial release
// ============================================================================
module time_keeper_bcd
   import clock_pkg::*;
#(
   parameter int unsigned INIT_HOUR = 0,
   parameter int unsigned INIT_MIN  = 0,
   parameter int unsigned INIT_SEC  = 0
) (
   input  logic       clk_27MHz,
   input  logic       rst,
   input  logic       clk_1Hz_en,
   input  logic       set_mode,
   input  logic [1:0] set_sel,
   input  logic       set_inc,
   input  logic       load_valid,
   input  logic [7:0] load_hour,
   input  logic [7:0] load_min,
   input  logic [7:0] load_sec,
   output logic       load_err,
   output logic [7:0] hour_bcd,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       min_carry,
   output logic       hour_carry,
`ifdef HOUR12_MODE_EN
   output logic       day_carry,
   input  logic       load_pm,
   output logic       pm
`else
   output logic       day_carry
`endif
);

   localparam field_t INIT_HOUR_BCD = bin_to_bcd(7'(INIT_HOUR));
   localparam field_t INIT_MIN_BCD  = bin_to_bcd(7'(INIT_MIN));
   localparam field_t INIT_SEC_BCD  = bin_to_bcd(7'(INIT_SEC));

   field_t sec_val, min_val, hour_val;
   field_t w_load_hour24;
   logic   w_hour_ok, w_load_ok, w_load_acc;
   logic   w_tick, w_adj;
   logic   w_sec_inc, w_min_inc, w_hour_inc;
   logic   w_sec_wrap, w_min_wrap, w_hour_wrap;

   logic   min_carry_q, min_carry_d;
   logic   hour_carry_q, hour_carry_d;
   logic   day_carry_q, day_carry_d;
   logic   load_err_q, load_err_d;

   // Load validation and conversion of the load hour into internal 24-hour form
   always_comb begin
`ifdef HOUR12_MODE_EN
      w_hour_ok     = bcd_legal(load_hour, MAX_HOUR12) && (load_hour != 8'h00);
      w_load_hour24 = hour12_to_24(load_hour, load_pm);
`else
      w_hour_ok     = bcd_legal(load_hour, MAX_HOUR);
      w_load_hour24 = load_hour;
`endif
      w_load_ok = w_hour_ok && bcd_legal(load_min, MAX_MIN) && bcd_legal(load_sec, MAX_SEC);
   end

   // Any load request owns the cycle, so a coincident tick or adjust is lost
   assign w_load_acc = load_valid && w_load_ok;
   assign w_tick     = clk_1Hz_en && !set_mode && !load_valid;
   assign w_adj      = set_mode && set_inc && !load_valid;

   // Ticks ripple through the wrap flags; adjusts touch one field only
   assign w_sec_inc  = w_tick || (w_adj && (set_sel == SEL_SEC));
   assign w_min_inc  = (w_tick && w_sec_wrap) || (w_adj && (set_sel == SEL_MIN));
   assign w_hour_inc = (w_tick && w_min_wrap) || (w_adj && (set_sel == SEL_HOUR));

   bcd_mod_counter #(
      .MAX_VAL  (MAX_SEC),
      .INIT_VAL (INIT_SEC_BCD)
   ) u_sec (
      .clk        (clk_27MHz),
      .rst        (rst),
      .i_inc      (w_sec_inc),
      .i_load     (w_load_acc),
      .i_load_val (load_sec),
      .o_value    (sec_val),
      .o_wrap     (w_sec_wrap)
   );

   bcd_mod_counter #(
      .MAX_VAL  (MAX_MIN),
      .INIT_VAL (INIT_MIN_BCD)
   ) u_min (
      .clk        (clk_27MHz),
      .rst        (rst),
      .i_inc      (w_min_inc),
      .i_load     (w_load_acc),
      .i_load_val (load_min),
      .o_value    (min_val),
      .o_wrap     (w_min_wrap)
   );

   bcd_mod_counter #(
      .MAX_VAL  (MAX_HOUR),
      .INIT_VAL (INIT_HOUR_BCD)
   ) u_hour (
      .clk        (clk_27MHz),
      .rst        (rst),
      .i_inc      (w_hour_inc),
      .i_load     (w_load_acc),
      .i_load_val (w_load_hour24),
      .o_value    (hour_val),
      .o_wrap     (w_hour_wrap)
   );

   // Pulse conditions; carries only come from the tick path
   always_comb begin
      min_carry_d  = w_tick && w_sec_wrap;
      hour_carry_d = w_tick && w_min_wrap;
      day_carry_d  = w_tick && w_hour_wrap;
      load_err_d   = load_valid && !w_load_ok;
   end

   // Pulse registers, aligned with the field update they describe
   always_ff @(posedge clk_27MHz) begin
      if (rst) begin
         min_carry_q  <= 1'b0;
         hour_carry_q <= 1'b0;
         day_carry_q  <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         min_carry_q  <= min_carry_d;
         hour_carry_q <= hour_carry_d;
         day_carry_q  <= day_carry_d;
         load_err_q   <= load_err_d;
      end
   end

   assign min_carry  = min_carry_q;
   assign hour_carry = hour_carry_q;
   assign day_carry  = day_carry_q;
   assign load_err   = load_err_q;
   assign sec_bcd    = sec_val;
   assign min_bcd    = min_val;

`ifdef HOUR12_MODE_EN
   localparam logic [8:0] INIT_DISP = hour24_to_12(INIT_HOUR_BCD);

   field_t w_hour_next;
   field_t hour_disp_q, hour_disp_d;
   logic   pm_q, pm_d;

   // Mirror the hour counter's next value so the 12-hour stage keeps latency 1
   always_comb begin
      w_hour_next = hour_val;
      if (w_load_acc)
         w_hour_next = w_load_hour24;
      else if (w_hour_inc)
         w_hour_next = bcd_inc(hour_val, MAX_HOUR);
      {pm_d, hour_disp_d} = hour24_to_12(w_hour_next);
   end

   // Registered 12-hour display stage
   always_ff @(posedge clk_27MHz) begin
      if (rst) begin
         pm_q        <= INIT_DISP[8];
         hour_disp_q <= INIT_DISP[7:0];
      end else begin
         pm_q        <= pm_d;
         hour_disp_q <= hour_disp_d;
      end
   end

   assign hour_bcd = hour_disp_q;
   assign pm       = pm_q;
`else
   assign hour_bcd = hour_val;
`endif

endmodule
`default_nettype wire

// File: tb/tb_time_keeper_bcd.sv
`default_nettype none
// ============================================================================
// Module      : tb_time_keeper_bcd
// Description : Self-checking bench for time_keeper_bcd (24-hour build).
//               Directed steps followed by randomized traffic, all compared
//               against a seconds-since-midnight reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_time_keeper_bcd;

   localparam int INIT_H = 13;
   localparam int INIT_M = 45;
   localparam int INIT_S = 7;

   logic       clk_27MHz = 1'b0;
   logic       rst = 1'b1;
   logic       clk_1Hz_en = 1'b0;
   logic       set_mode = 1'b0;
   logic [1:0] set_sel = 2'd3;
   logic       set_inc = 1'b0;
   logic       load_valid = 1'b0;
   logic [7:0] load_hour = 8'h00;
   logic [7:0] load_min = 8'h00;
   logic [7:0] load_sec = 8'h00;
   logic       load_err;
   logic [7:0] hour_bcd, min_bcd, sec_bcd;
   logic       min_carry, hour_carry, day_carry;

   int checks = 0;
   int errors = 0;

   // reference model state
   int   m_h, m_m, m_s;
   logic e_min_c, e_hour_c, e_day_c, e_err;

   logic [7:0] r_lh, r_lm, r_ls;
   logic       r_r, r_t, r_sm, r_si, r_lv;
   logic [1:0] r_ss;

   time_keeper_bcd #(
      .INIT_HOUR (INIT_H),
      .INIT_MIN  (INIT_M),
      .INIT_SEC  (INIT_S)
   ) dut (
      .clk_27MHz  (clk_27MHz),
      .rst        (rst),
      .clk_1Hz_en (clk_1Hz_en),
      .set_mode   (set_mode),
      .set_sel    (set_sel),
      .set_inc    (set_inc),
      .load_valid (load_valid),
      .load_hour  (load_hour),
      .load_min   (load_min),
      .load_sec   (load_sec),
      .load_err   (load_err),
      .hour_bcd   (hour_bcd),
      .min_bcd    (min_bcd),
      .sec_bcd    (sec_bcd),
      .min_carry  (min_carry),
      .hour_carry (hour_carry),
      .day_carry  (day_carry)
   );

   always #5 clk_27MHz = ~clk_27MHz;

   function automatic logic [7:0] to_bcd(input int v);
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic int bcd_val(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic bit bcd_ok(input logic [7:0] v, input int maxdec);
      return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (bcd_val(v) <= maxdec);
   endfunction

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // Advance the model by one clock using the inputs that were presented
   task automatic model(input logic r, input logic t, input logic sm, input logic [1:0] ss,
                        input logic si, input logic lv,
                        input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
      int secs;
      e_min_c  = 1'b0;
      e_hour_c = 1'b0;
      e_day_c  = 1'b0;
      e_err    = 1'b0;
      if (r) begin
         m_h = INIT_H; m_m = INIT_M; m_s = INIT_S;
      end else if (lv) begin
         if (bcd_ok(lh, 23) && bcd_ok(lm, 59) && bcd_ok(ls, 59)) begin
            m_h = bcd_val(lh); m_m = bcd_val(lm); m_s = bcd_val(ls);
         end else begin
            e_err = 1'b1;
         end
      end else if (sm) begin
         if (si) begin
            case (ss)
               2'd0: m_s = (m_s + 1) % 60;
               2'd1: m_m = (m_m + 1) % 60;
               2'd2: m_h = (m_h + 1) % 24;
               default: ;
            endcase
         end
      end else if (t) begin
         secs = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
         m_h = secs / 3600;
         m_m = (secs / 60) % 60;
         m_s = secs % 60;
         e_min_c  = (m_s == 0);
         e_hour_c = (m_s == 0) && (m_m == 0);
         e_day_c  = (secs == 0);
      end
   endtask

   task automatic check_all();
      chk8("hour", hour_bcd, to_bcd(m_h));
      chk8("min", min_bcd, to_bcd(m_m));
      chk8("sec", sec_bcd, to_bcd(m_s));
      chk1("min_carry", min_carry, e_min_c);
      chk1("hour_carry", hour_carry, e_hour_c);
      chk1("day_carry", day_carry, e_day_c);
      chk1("load_err", load_err, e_err);
   endtask

   // Present inputs, clock once, update the model, then compare after the edge
   task automatic step(input logic r, input logic t, input logic sm, input logic [1:0] ss,
                       input logic si, input logic lv,
                       input logic [7:0] lh, input logic [7:0] lm, input logic [7:0] ls);
      rst = r; clk_1Hz_en = t; set_mode = sm; set_sel = ss; set_inc = si;
      load_valid = lv; load_hour = lh; load_min = lm; load_sec = ls;
      @(posedge clk_27MHz);
      model(r, t, sm, ss, si, lv, lh, lm, ls);
      #1;
      check_all();
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic tick();
      step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   task automatic load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
      step(1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, h, m, s);
   endtask

   task automatic adj(input logic [1:0] sel);
      step(1'b0, 1'b0, 1'b1, sel, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
   endtask

   initial begin
      // reset state
      step(1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      step(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      chk8("rst_hour", hour_bcd, 8'h13);
      chk8("rst_min", min_bcd, 8'h45);
      chk8("rst_sec", sec_bcd, 8'h07);
      idle();

      // 60 ticks from midnight
      load(8'h00, 8'h00, 8'h00);
      for (int i = 0; i < 60; i++) begin
         tick();
         idle();
      end
      chk8("t60_sec", sec_bcd, 8'h00);
      chk8("t60_min", min_bcd, 8'h01);

      // day rollover
      load(8'h23, 8'h59, 8'h58);
      tick();
      idle();
      tick();
      chk1("day_min_c", min_carry, 1'b1);
      chk1("day_hour_c", hour_carry, 1'b1);
      chk1("day_day_c", day_carry, 1'b1);
      chk8("day_hour", hour_bcd, 8'h00);
      idle();

      // rejected loads
      load(8'h07, 8'h08, 8'h09);
      load(8'h24, 8'h00, 8'h00);
      chk1("rej_hour_err", load_err, 1'b1);
      chk8("rej_hour_keep", hour_bcd, 8'h07);
      idle();
      load(8'h10, 8'h5A, 8'h00);
      chk1("rej_min_err", load_err, 1'b1);
      chk8("rej_min_keep", min_bcd, 8'h08);
      load(8'h10, 8'h00, 8'h60);
      idle();

      // minute adjust x61 with ticks presented (dropped)
      load(8'h05, 8'h00, 8'h30);
      for (int i = 0; i < 61; i++)
         step(1'b0, i[0], 1'b1, 2'd1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
      step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      chk8("adj_min", min_bcd, 8'h01);
      chk8("adj_hour", hour_bcd, 8'h05);
      chk8("adj_sec", sec_bcd, 8'h30);

      // 19 -> 20 hour digit roll
      load(8'h19, 8'h59, 8'h59);
      tick();
      chk8("h19_20", hour_bcd, 8'h20);

      // adjust wraps without carries, sel 3 no effect
      load(8'h23, 8'h59, 8'h59);
      adj(2'd0);
      adj(2'd2);
      adj(2'd3);
      chk8("adjw_hour", hour_bcd, 8'h00);
      chk8("adjw_sec", sec_bcd, 8'h00);

      // load and tick together: load wins
      step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00);
      chk8("ld_tick_sec", sec_bcd, 8'h00);
      chk8("ld_tick_hour", hour_bcd, 8'h12);
      idle();

      // reset with tick at 00:00:59
      load(8'h00, 8'h00, 8'h59);
      step(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      chk1("rst_tick_mc", min_carry, 1'b0);
      chk8("rst_tick_min", min_bcd, 8'h45);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         r_r  = ($urandom_range(0, 199) == 0);
         r_lv = ($urandom_range(0, 15) == 0);
         r_t  = ($urandom_range(0, 9) < 6);
         r_sm = ($urandom_range(0, 4) == 0);
         r_si = $urandom_range(0, 1) == 1;
         r_ss = 2'($urandom_range(0, 3));
         r_lh = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                : {4'($urandom_range(0, 2)), 4'($urandom_range(0, 9))};
         r_lm = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                : {4'($urandom_range(4, 5)), 4'($urandom_range(0, 9))};
         r_ls = ($urandom_range(0, 7) == 0) ? 8'($urandom)
                : {4'd5, 4'($urandom_range(0, 9))};
         step(r_r, r_t, r_sm, r_ss, r_si, r_lv, r_lh, r_lm, r_ls);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/time_keeper_bcd.md
Name: time_keeper_bcd

Overview:
Time-of-day counter directly downstream of the 1 Hz enable divider. Consumes the single-cycle 1 Hz enable pulse and keeps seconds, minutes and hours as packed BCD. Provides per-field manual adjustment and a validated parallel load for the user-set path. Emits carry pulses for the chime and date logic. Feeds the display scan and segment decode stages.

Parameters:
INIT_HOUR, 0, hour value after reset (binary, 0..23)
INIT_MIN, 0, minute value after reset (binary, 0..59)
INIT_SEC, 0, second value after reset (binary, 0..59)

Ports:
clk_27MHz  input  1  system clock, 27 MHz
rst  input  1  synchronous, active-high reset
clk_1Hz_en  input  1  one-cycle tick from the 1 s divider
set_mode  input  1  1 = adjust mode; ticks are ignored while high
set_sel  input  2  field to adjust: 0 = sec, 1 = min, 2 = hour, 3 = none
set_inc  input  1  one-cycle pulse; increments the selected field
load_valid  input  1  one-cycle pulse; load the three BCD inputs
load_hour  input  8  BCD hour for load
load_min  input  8  BCD minute for load
load_sec  input  8  BCD second for load
load_err  output  1  one-cycle pulse: the load was rejected as out of range
hour_bcd  output  8  {tens, units}
min_bcd  output  8  {tens, units}
sec_bcd  output  8  {tens, units}
min_carry  output  1  one-cycle pulse when seconds wrap 59 -> 00 on a tick
hour_carry  output  1  one-cycle pulse when minutes wrap 59 -> 00 via a tick carry
day_carry  output  1  one-cycle pulse when the time wraps 23:59:59 -> 00:00:00

Behaviour:
- Single clock domain. All state updates on the rising edge of clk_27MHz.
- Reset is synchronous and active-high. On reset:
  - time = INIT_HOUR:INIT_MIN:INIT_SEC, converted to BCD at elaboration.
  - all pulse outputs = 0.
- Priority on each cycle, highest first: rst > load_valid > set_inc (set_mode=1) > clk_1Hz_en (set_mode=0).
- Tick path (clk_1Hz_en=1, set_mode=0, no higher-priority event):
  - Units digit increments. At 9 it wraps to 0 and the tens digit increments.
  - Seconds: 59 -> 00 increments minutes and asserts min_carry.
  - Minutes: 59 -> 00 increments hours and asserts hour_carry.
  - Hours: 23 -> 00 asserts day_carry. At 19 -> 20 the units wrap and the tens go to 2.
  - New value is visible on the outputs the cycle after the tick (latency 1). Carries are registered and coincide with the new value.
- Adjust path (set_mode=1, set_inc=1):
  - Selected field increments modulo its range (60 or 24).
  - No carry into other fields and no carry pulses.
  - set_sel=3: no effect.
- Ticks arriving while set_mode=1 are dropped, not queued.
- Load path:
  - Accepted only if every digit is <= 9, hour <= 0x23, min <= 0x59 and sec <= 0x59.
  - Accepted: all fields take the load values next cycle.
  - Rejected: time is unchanged and load_err pulses for 1 cycle.
  - A load in the same cycle as a tick wins; that tick is lost.
- Internal digits never leave their legal ranges.
- An illegal state (e.g. after a glitch) is forced to 00 in the next tick/adjust on that field.
- A reset arriving in the middle of any operation overrides it; no pulse output is asserted in the reset cycle.

Optional Feature:
Macro HOUR12_MODE_EN.
- Defined:
  - hour_bcd shows 12-hour format 0x01..0x12.
  - Extra output pm (1 bit, reset value = INIT_HOUR >= 12) toggles on the 11:59:59 -> 12:00:00 tick.
  - day_carry fires at the 11:59:59 PM -> 12:00:00 AM transition.
  - Loads accept hours 0x01..0x12, with pm taken from an extra input load_pm.
  - Internal state stays 24-hour; the conversion is a registered output stage, so latency remains 1.
- Undefined: 24-hour behaviour as above; no pm or load_pm ports.

Decomposition:
- Shared package clock_pkg holds:
  - SEL_SEC/SEL_MIN/SEL_HOUR/SEL_NONE encodings
  - BCD digit type (4 bits) and field type (8 bits)
  - constants MAX_SEC=0x59, MAX_MIN=0x59, MAX_HOUR=0x23
- One natural sub-module, bcd_mod_counter:
  - 2-digit BCD counter with a parameter for the maximum value.
  - Inputs: inc, load, load value.
  - Outputs: value, wrap pulse.
  - Instantiated three times.

Test Plan:
- Reset then 60 ticks -> sec_bcd 0x00, min_bcd 0x01, a single min_carry pulse aligned with the 0x59 -> 0x00 transition.
- Load 23:59:58, then 2 ticks -> 00:00:00; min_carry, hour_carry and day_carry all pulse in the same cycle, one cycle after the second tick.
- Load hour 0x24 (and separately min 0x5A) -> load_err pulses once, time unchanged.
- set_mode=1, set_sel=1, set_inc ×61 from min 0x00 -> min 0x01, hour unchanged, no carries; ticks during this window leave sec_bcd unchanged.
- load_valid and clk_1Hz_en asserted in the same cycle with load 12:00:00 -> output is exactly 12:00:00, not 12:00:01.
- rst asserted on the same cycle as a tick at 00:00:59 -> the INIT values appear and min_carry stays 0.
